apu_sound_scheduler: RTL and testbench
======================================

# apu_sound_scheduler

Sequences the audio processing unit's three voices from game-event requests. Latches sound requests for eat, hit and die events, grants one at a time by fixed priority, and issues a one-cycle trigger to the matching APU voice (saw, square, noise). It then holds the grant for a per-sound number of video frames while generating a decaying 4-bit volume. Sits between the event/collision logic and the APU, clocked by the pixel clock, with frame timing taken from the VGA sync generator.

## Interface
Parameters:
- `EAT_FRAMES`, default 8: duration of the eat sound (saw voice) in frames; legal range 1–63.
- `HIT_FRAMES`, default 12: duration of the hit sound (square voice) in frames; legal range 1–63.
- `DIE_FRAMES`, default 30: duration of the die sound (noise voice) in frames; legal range 1–63.

Ports:
- `clk` in 1: pixel clock; single clock domain.
- `rst_n` in 1: asynchronous active-low reset.
- `frame_end` in 1: one-cycle pulse, once per video frame.
- `eat_req` in 1: eat event; any high cycle posts a request.
- `hit_req` in 1: hit event; any high cycle posts a request.
- `die_req` in 1: die event; any high cycle posts a request.
- `saw_trigger` out 1: one-cycle start pulse to the APU saw voice.
- `square_trigger` out 1: one-cycle start pulse to the APU square voice.
- `noise_trigger` out 1: one-cycle start pulse to the APU noise voice.
- `active_voice` out 2: current grant. 00 none, 01 saw, 10 square, 11 noise.
- `volume` out 4: envelope level for the active voice; 0 when idle.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Priority is fixed: die > hit > eat.
- `pending[2:0]` register:
  - Each bit is set by its request input.
  - The bit is cleared in the cycle its source is granted (enters START).
  - If a request arrives in the same cycle as its own grant, it is absorbed (no re-post).
  - Multiple requests for the same source while it is pending collapse into one.
- States:
  - IDLE: `active_voice`=0, `volume`=0. If any pending bit is set, grant the highest priority and go to START.
  - START (exactly 1 cycle): assert the granted voice's trigger; `active_voice`=granted; `volume`=15; load `frames_left`=DUR−1 (6-bit); go to PLAY. `frame_end` in this cycle is ignored.
  - PLAY, on `frame_end`:
    - If `frames_left`==0, go to IDLE.
    - Otherwise decrement `frames_left` and decrement `volume`, saturating at 1.
  - PLAY, same-source request: stays pending and plays again after the current sound ends.
- Duration: a sound consumes exactly DUR `frame_end` pulses in PLAY; the DUR-th pulse returns to IDLE.
- Trigger outputs are mutually exclusive and asserted only in START.
- Out-of-range parameters are compile-time errors (elaboration assertion).

## Timing
- Reset (asynchronous, immediate): state IDLE, `pending`=0, `frames_left`=0. All outputs 0: triggers, `active_voice`, `volume`, `busy`.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- Latency: request high in cycle 0 → pending set in cycle 1 → trigger, `active_voice`, `volume`=15 and `busy` high in cycle 2 (from IDLE).
- End of sound: the cycle after the final `frame_end` shows IDLE outputs. If a request is pending, the next START follows 1 cycle later.
- Simultaneous requests in IDLE: the highest-priority source is granted; the others remain pending and are served in priority order.
- Reset asserted mid-sound: outputs clear immediately; pending requests are lost.

## Configuration
- `APU_SCHED_PREEMPT_EN` defined: in PLAY, a pending source of strictly higher priority than the current grant sends the FSM to START on the next edge with the new source. This check takes precedence over a coincident `frame_end`. The preempted sound is dropped, not resumed.
- Not defined: higher-priority requests wait in `pending` until the current sound completes.

## Test plan
- Reset: hold `rst_n`=0 with all requests high → all outputs 0. Release, one eat pulse → `saw_trigger` high in cycle 2 only; `active_voice`=01; `volume`=15.
- Duration/envelope, `EAT_FRAMES`=8: after the trigger, 8 `frame_end` pulses → `volume` sequence 15,14,…,8; `busy` drops the cycle after the 8th pulse.
- Simultaneous eat+hit+die in IDLE → grants in order noise, square, saw, each after the previous completes; exactly one trigger per grant.
- Repeated `hit_req` pulses (×5) during its own PLAY → exactly one additional square sound afterward.
- With `APU_SCHED_PREEMPT_EN`: die request during eat PLAY → `noise_trigger` 2 cycles later; no further `saw_trigger`.
- Without `APU_SCHED_PREEMPT_EN`: same stimulus → eat completes, then `noise_trigger`.
- Mid-sound reset at frame 3 of die → outputs 0 immediately; no trigger after release without a new request.

Source files
------------

// File: rtl/apu_sound_scheduler.sv
// Fixed-priority scheduler for the APU's saw/square/noise voices with a per-frame decaying volume.
// Optional feature macro: APU_SCHED_PREEMPT_EN (higher-priority pending requests cut the current sound).
module apu_sound_scheduler #(
    parameter int EAT_FRAMES = 8,
    parameter int HIT_FRAMES = 12,
    parameter int DIE_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_end,
    input  logic       eat_req,
    input  logic       hit_req,
    input  logic       die_req,
    output logic       saw_trigger,
    output logic       square_trigger,
    output logic       noise_trigger,
    output logic [1:0] active_voice,
    output logic [3:0] volume,
    output logic       busy
);

    if (EAT_FRAMES < 1 || EAT_FRAMES > 63 ||
        HIT_FRAMES < 1 || HIT_FRAMES > 63 ||
        DIE_FRAMES < 1 || DIE_FRAMES > 63) begin : g_bad_param
        $error("apu_sound_scheduler: frame counts must be in 1..63");
    end

    localparam logic [5:0] EAT_LAST = 6'(EAT_FRAMES - 1);
    localparam logic [5:0] HIT_LAST = 6'(HIT_FRAMES - 1);
    localparam logic [5:0] DIE_LAST = 6'(DIE_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, START, PLAY} state_t;

    state_t     state_q, state_d;
    logic [2:0] pending_q, pending_d;
    logic [5:0] frames_left_q, frames_left_d;
    logic [1:0] active_q, active_d;
    logic [3:0] volume_q, volume_d;
    logic [2:0] trig_q, trig_d;
    logic       busy_q, busy_d;

    logic [1:0] top_code;
    logic       do_start;
    logic [2:0] req_vec;

    // Voice code doubles as priority: noise(3) > square(2) > saw(1).
    always_comb begin
        top_code = 2'd0;
        if (pending_q[2])      top_code = 2'd3;
        else if (pending_q[1]) top_code = 2'd2;
        else if (pending_q[0]) top_code = 2'd1;
    end

    assign req_vec = {die_req, hit_req, eat_req};

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q | req_vec;
        frames_left_d = frames_left_q;
        active_d      = active_q;
        volume_d      = volume_q;
        trig_d        = 3'b000;
        do_start      = 1'b0;

        case (state_q)
            IDLE: begin
                if (top_code != 2'd0) do_start = 1'b1;
            end
            START: begin
                state_d = PLAY;
            end
            PLAY: begin
`ifdef APU_SCHED_PREEMPT_EN
                if (top_code > active_q) begin
                    do_start = 1'b1;
                end else
`endif
                if (frame_end) begin
                    if (frames_left_q == 6'd0) begin
                        state_d  = IDLE;
                        active_d = 2'd0;
                        volume_d = 4'd0;
                    end else begin
                        frames_left_d = frames_left_q - 6'd1;
                        volume_d      = (volume_q > 4'd1) ? volume_q - 4'd1 : 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A request coinciding with its own grant is absorbed by the clear.
        if (do_start) begin
            state_d  = START;
            active_d = top_code;
            volume_d = 4'd15;
            case (top_code)
                2'd3:    begin frames_left_d = DIE_LAST; trig_d = 3'b100; end
                2'd2:    begin frames_left_d = HIT_LAST; trig_d = 3'b010; end
                default: begin frames_left_d = EAT_LAST; trig_d = 3'b001; end
            endcase
            pending_d = (pending_q | req_vec) & ~trig_d;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pending_q     <= 3'b000;
            frames_left_q <= 6'd0;
            active_q      <= 2'd0;
            volume_q      <= 4'd0;
            trig_q        <= 3'b000;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            frames_left_q <= frames_left_d;
            active_q      <= active_d;
            volume_q      <= volume_d;
            trig_q        <= trig_d;
            busy_q        <= busy_d;
        end
    end

    assign saw_trigger    = trig_q[0];
    assign square_trigger = trig_q[1];
    assign noise_trigger  = trig_q[2];
    assign active_voice   = active_q;
    assign volume         = volume_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_apu_sound_scheduler.sv
// Bench for apu_sound_scheduler: vector table plus hand sequences; a trigger scoreboard checks grant order.
module tb_apu_sound_scheduler;

    localparam int EAT_D = 8;
    localparam int HIT_D = 12;
    localparam int DIE_D = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_end = 1'b0;
    logic       eat_req = 1'b0, hit_req = 1'b0, die_req = 1'b0;
    logic       saw_trigger, square_trigger, noise_trigger;
    logic [1:0] active_voice;
    logic [3:0] volume;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic [1:0] expq[$];

    apu_sound_scheduler #(.EAT_FRAMES(EAT_D), .HIT_FRAMES(HIT_D), .DIE_FRAMES(DIE_D)) dut (
        .clk(clk), .rst_n(rst_n), .frame_end(frame_end),
        .eat_req(eat_req), .hit_req(hit_req), .die_req(die_req),
        .saw_trigger(saw_trigger), .square_trigger(square_trigger), .noise_trigger(noise_trigger),
        .active_voice(active_voice), .volume(volume), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int dur_of(input logic [1:0] c);
        case (c)
            2'd3:    return DIE_D;
            2'd2:    return HIT_D;
            default: return EAT_D;
        endcase
    endfunction

    function automatic int trig_code();
        return {30'd0, square_trigger | noise_trigger, saw_trigger | noise_trigger};
    endfunction

    // Scoreboard: every trigger pulse must match the next expected grant.
    always @(negedge clk) begin
        if (rst_n && (saw_trigger || square_trigger || noise_trigger)) begin
            chk("trig_onehot", int'(saw_trigger) + int'(square_trigger) + int'(noise_trigger), 1);
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_trigger: got %0d want none", trig_code());
            end else begin
                chk("trig_order", trig_code(), int'(expq.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input logic [2:0] r);
        die_req = r[2]; hit_req = r[1]; eat_req = r[0];
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_active"}, int'(active_voice), 0);
        chk({name, "_vol"}, int'(volume), 0);
        chk({name, "_trig"}, trig_code(), 0);
    endtask

    // Called in the cycle the START outputs are visible; returns in the first IDLE cycle.
    task automatic play_check(input logic [1:0] code, input int dur, input logic [2:0] inj, input int inj_n);
        chk("start_trig", trig_code(), int'(code));
        chk("start_active", int'(active_voice), int'(code));
        chk("start_vol", int'(volume), 15);
        chk("start_busy", int'(busy), 1);
        tick();
        chk("play_trig_low", trig_code(), 0);
        chk("play_vol15", int'(volume), 15);
        for (int k = 1; k <= dur; k++) begin
            frame_end = 1'b1;
            if (k <= inj_n) set_req(inj);
            tick();
            frame_end = 1'b0;
            set_req(3'b000);
            if (k < dur) begin
                chk("env_vol", int'(volume), (15 - k > 1) ? 15 - k : 1);
                chk("env_busy", int'(busy), 1);
                chk("env_active", int'(active_voice), int'(code));
            end else begin
                chk_idle("end");
            end
        end
    endtask

    typedef struct {
        logic [2:0] req;
        int         hold;
        int         n;
        logic [1:0] c[3];
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{req: 3'b001, hold: 1, n: 1, c: '{2'd1, 2'd0, 2'd0}};
        vt[1] = '{req: 3'b010, hold: 1, n: 1, c: '{2'd2, 2'd0, 2'd0}};
        vt[2] = '{req: 3'b100, hold: 1, n: 1, c: '{2'd3, 2'd0, 2'd0}};
        vt[3] = '{req: 3'b111, hold: 1, n: 3, c: '{2'd3, 2'd2, 2'd1}};
        vt[4] = '{req: 3'b011, hold: 1, n: 2, c: '{2'd2, 2'd1, 2'd0}};
        vt[5] = '{req: 3'b101, hold: 1, n: 2, c: '{2'd3, 2'd1, 2'd0}};
        vt[6] = '{req: 3'b001, hold: 2, n: 1, c: '{2'd1, 2'd0, 2'd0}};

        // Reset with every input hammered high.
        set_req(3'b111);
        frame_end = 1'b1;
        #3;
        chk_idle("rst_async");
        repeat (3) tick();
        chk_idle("rst_hold");
        set_req(3'b000);
        frame_end = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_idle("rst_release");

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < vt[i].n; j++) expq.push_back(vt[i].c[j]);
            set_req(vt[i].req);
            tick();
            chk("lat_cycle1_busy", int'(busy), 0);
            chk("lat_cycle1_trig", trig_code(), 0);
            if (vt[i].hold < 2) set_req(3'b000);
            tick();
            set_req(3'b000);
            for (int j = 0; j < vt[i].n; j++) begin
                play_check(vt[i].c[j], dur_of(vt[i].c[j]), 3'b000, 0);
                if (j < vt[i].n - 1) tick();
            end
            repeat (3) tick();
            chk_idle("vec_idle");
        end

        // Five hit pulses during its own sound collapse into one replay.
        expq.push_back(2'd2);
        expq.push_back(2'd2);
        set_req(3'b010);
        tick();
        set_req(3'b000);
        tick();
        play_check(2'd2, HIT_D, 3'b010, 5);
        tick();
        play_check(2'd2, HIT_D, 3'b000, 0);
        repeat (20) tick();
        chk_idle("hit_collapse_idle");

        // Die request during eat play.
        expq.push_back(2'd1);
        expq.push_back(2'd3);
        set_req(3'b001);
        tick();
        set_req(3'b000);
        tick();
`ifdef APU_SCHED_PREEMPT_EN
        chk("pre_saw", trig_code(), 1);
        tick();
        repeat (2) begin
            frame_end = 1'b1; tick(); frame_end = 1'b0;
        end
        set_req(3'b100);
        tick();
        set_req(3'b000);
        chk("pre_cycle1_active", int'(active_voice), 1);
        chk("pre_cycle1_trig", trig_code(), 0);
        tick();
        play_check(2'd3, DIE_D, 3'b000, 0);
`else
        play_check(2'd1, EAT_D, 3'b100, 2);
        tick();
        play_check(2'd3, DIE_D, 3'b000, 0);
`endif
        repeat (10) tick();
        chk_idle("die_after_eat_idle");

        // Reset at frame 3 of die, with an eat request pending.
        expq.push_back(2'd3);
        set_req(3'b100);
        tick();
        set_req(3'b000);
        tick();
        chk("mid_start", trig_code(), 3);
        tick();
        repeat (3) begin
            frame_end = 1'b1; tick(); frame_end = 1'b0;
        end
        set_req(3'b001);
        tick();
        set_req(3'b000);
        chk("mid_vol", int'(volume), 12);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("mid_rst");
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            frame_end = (k % 5 == 0);
            tick();
        end
        frame_end = 1'b0;
        chk_idle("mid_rst_after");

        chk("queue_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
